// File: rtl/mblight_onchip_ram_dp.sv
// mblight_onchip_ram_dp
//   True-dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2), a
//   configurable read latency and an optional zero-fill sequencer that runs
//   after every reset.
//
// Ports
//   clk, reset         single clock, asynchronous active-high reset
//   clken, reset_req   effective enable en = clken & ~reset_req
//   init_busy          high while the zero-fill sequencer runs
//   sX_address         word address (X = 1, 2)
//   sX_chipselect/read/write, sX_byteenable, sX_writedata   request
//   sX_readdata, sX_readdatavalid                             response
//   sX_waitrequest                                            back-pressure
module mblight_onchip_ram_dp #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 13,
    parameter int DEPTH          = 8192,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clken,
    input  logic                    reset_req,
    output logic                    init_busy,

    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,

    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                 state;
    logic [IW-1:0]          clr_cnt;
    logic                   en;
    logic                   wait_all;
    logic [DATA_WIDTH-1:0]  mem [0:DEPTH-1];

    // Port 0 = s1, port 1 = s2
    logic [1:0][ADDR_WIDTH-1:0] p_addr;
    logic [1:0]                 p_cs, p_rd, p_wr;
    logic [1:0][BYTES-1:0]      p_be;
    logic [1:0][DATA_WIDTH-1:0] p_wd, p_rdata;
    logic [1:0]                 p_rvalid, acc_rd, acc_wr, in_range;
    logic [1:0][IW-1:0]         p_idx;

    assign p_addr = {s2_address, s1_address};
    assign p_cs   = {s2_chipselect, s1_chipselect};
    assign p_rd   = {s2_read, s1_read};
    assign p_wr   = {s2_write, s1_write};
    assign p_be   = {s2_byteenable, s1_byteenable};
    assign p_wd   = {s2_writedata, s1_writedata};

    assign en       = clken & ~reset_req;
    // reset term keeps waitrequest high during reset even when no clear runs
    assign wait_all = reset | (state == CLEAR) | ~en;

    assign s1_waitrequest   = wait_all;
    assign s2_waitrequest   = wait_all;
    assign s1_readdata      = p_rdata[0];
    assign s2_readdata      = p_rdata[1];
    assign s1_readdatavalid = p_rvalid[0];
    assign s2_readdatavalid = p_rvalid[1];
    assign init_busy        = (state == CLEAR);

    // Sequencer: one zero word per enabled cycle, then hand over to the ports
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else if (en && state == CLEAR) begin
            if (clr_cnt == IW'(DEPTH - 1)) state <= READY;
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Array writes. s2 is applied first so s1 overrides it on shared lanes.
    always_ff @(posedge clk) begin
        if (en && !reset) begin
            if (state == CLEAR) begin
                mem[clr_cnt] <= '0;
            end else begin
                for (int p = 1; p >= 0; p--) begin
                    if (acc_wr[p] && in_range[p]) begin
                        for (int b = 0; b < BYTES; b++) begin
                            if (p_be[p][b]) mem[p_idx[p]][b*8 +: 8] <= p_wd[p][b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < 2; p++) begin : g_port
            logic [DATA_WIDTH-1:0]                  rd_word;
            logic [READ_LATENCY:1]                  vld_pipe;
            logic [READ_LATENCY:1][DATA_WIDTH-1:0]  dat_pipe;

            assign in_range[p] = {1'b0, p_addr[p]} < (ADDR_WIDTH + 1)'(DEPTH);
            assign p_idx[p]    = p_addr[p][IW-1:0];
            // write wins over read on the same port
            assign acc_wr[p]   = p_cs[p] & p_wr[p] & ~wait_all;
            assign acc_rd[p]   = p_cs[p] & p_rd[p] & ~p_wr[p] & ~wait_all;
            // sampled before this edge's writes land, so reads see old data
            assign rd_word     = in_range[p] ? mem[p_idx[p]] : '0;

            // Data stages only load behind a valid so readdata holds otherwise
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else if (en) begin
                    vld_pipe[1] <= acc_rd[p];
                    if (acc_rd[p]) dat_pipe[1] <= rd_word;
                    for (int k = 2; k <= READ_LATENCY; k++) begin
                        vld_pipe[k] <= vld_pipe[k-1];
                        if (vld_pipe[k-1]) dat_pipe[k] <= dat_pipe[k-1];
                    end
                end
            end

            assign p_rvalid[p] = vld_pipe[READ_LATENCY];
            assign p_rdata[p]  = dat_pipe[READ_LATENCY];
        end
    endgenerate

endmodule

// File: doc/mblight_onchip_ram_dp.md
# mblight_onchip_ram_dp

Parametrised dual-port on-chip RAM for the Nios II subsystem, exposing two independent Avalon-MM slave ports (s1, s2) onto one true-dual-port memory array. It adds the following:
- configurable width, depth and read latency;
- `readdatavalid`/`waitrequest` handshakes;
- a defined write-collision and read-during-write policy;
- an optional hardware zero-fill sequencer run after reset.

It sits on the system interconnect as program/data memory or as a CPU-to-LED-pipeline buffer.

## Interface
- `DATA_WIDTH`, 32: word width in bits. Must be a multiple of 8.
- `ADDR_WIDTH`, 13: word address width.
- `DEPTH`, 8192: number of words. Must satisfy 2 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- `READ_LATENCY`, 1: read latency, 1 or 2 enabled cycles from acceptance to `readdatavalid`.
- `CLEAR_ON_RESET`, 1: 1 = zero-fill the array after every reset; 0 = contents undefined.

Ports:
- `clk`  in  1  single clock for both ports.
- `reset`  in  1  asynchronous, active-high reset.
- `clken`  in  1  global clock enable.
- `reset_req`  in  1  reset-request gate. Effective enable is `en = clken & ~reset_req`.
- `init_busy`  out  1  high while the zero-fill sequencer runs.
- `sX_address`  in  ADDR_WIDTH  word address (X = 1, 2).
- `sX_chipselect`, `sX_read`, `sX_write`  in  1  transfer qualifiers.
- `sX_byteenable`  in  DATA_WIDTH/8  byte lane enables for writes.
- `sX_writedata`  in  DATA_WIDTH  write data.
- `sX_readdata`  out  DATA_WIDTH  read data, valid only when `sX_readdatavalid` is high.
- `sX_readdatavalid`  out  1  read response strobe.
- `sX_waitrequest`  out  1  back-pressure.

## Operation
- **FSM states:** CLEAR, READY.
  - Reset → CLEAR if CLEAR_ON_RESET=1, otherwise READY.
  - CLEAR → READY when the clear counter has written DEPTH−1 on an enabled cycle.
- **CLEAR behaviour:**
  - Each enabled cycle writes all-zero to address `clr_cnt`, then increments `clr_cnt`.
  - Both `waitrequest` outputs are high; `init_busy` is high.
  - Host transfers are not accepted.
- **`waitrequest` rule:** `sX_waitrequest = (state==CLEAR) | ~en`. It is combinational, so a stalled master holds its request until acceptance.
- **Acceptance:** `acc_X = sX_chipselect & (sX_read | sX_write) & ~sX_waitrequest`.
  - Write takes priority over read on the same port: if both are high, the transfer is a write and no response is generated.
- **Writes:** only bytes with `byteenable` = 1 are updated. `byteenable` = 0 on all lanes is accepted as a no-op.
- **Out-of-range writes** (`address ≥ DEPTH`) are accepted and discarded.
- **Out-of-range reads** are accepted and return all-zero with a normal `readdatavalid`.
- **Same-address write collision** (both ports write the same word in the same cycle): s1 data wins on every byte lane s1 enables. s2 bytes on lanes that s1 does not enable are written. Both writes are acknowledged.
- **Read-during-write** (same port or cross port, same address, same cycle): the read returns the OLD data.
- **Disabled cycles** (`en` = 0) freeze everything: the read pipeline, `readdatavalid`, `readdata`, FSM state and `clr_cnt` all hold. No array write occurs.
- **Reset mid-operation** is asynchronous:
  - `clr_cnt` returns to 0 and the FSM re-enters CLEAR.
  - In-flight read responses are dropped with no `readdatavalid`.

## Timing
- **Reset values:**
  - `sX_readdata` = 0.
  - `sX_readdatavalid` = 0.
  - `sX_waitrequest` = 1 while `reset` is high.
  - `init_busy` = CLEAR_ON_RESET.
- **Clear duration:** exactly DEPTH enabled cycles after reset deassertion.
  - `init_busy` and `waitrequest` fall after the rising edge that writes address DEPTH−1.
  - Stalls on `en` extend the clear one-for-one.
- **Read latency:**
  - READ_LATENCY=1: `readdatavalid` rises in the enabled cycle after acceptance.
  - READ_LATENCY=2: one extra output register stage.
- **Throughput:** one accepted transfer per port per enabled cycle with back-to-back reads. Responses return in request order.
- `readdatavalid` is a one-cycle pulse per read, except when frozen by `en` = 0, in which case it is held.
- `readdata` keeps its last value when `readdatavalid` = 0.

## Test plan
- **Reset clear:** DEPTH=16, CLEAR_ON_RESET=1, `en` held high → `init_busy` high for exactly 16 cycles, `waitrequest` low on cycle 17, and reads of 0..15 all return 0x00000000.
- **Byte-enable write/read latency:** s1 writes 0xDEADBEEF to addr 5 with byteenable 4'b0101 over zeroed memory, then reads addr 5 → `readdata` = 0x00AD00EF. With READ_LATENCY=2, `readdatavalid` asserts exactly 2 cycles after acceptance.
- **Write collision:** in the same cycle, s1 writes 0x11111111 with be=4'b0011 and s2 writes 0x22222222 with be=4'b1111, both to addr 3 → readback 0x22221111.
- **Read-during-write:** addr 7 holds 0xA5A5A5A5. s1 writes 0x5A5A5A5A to addr 7 while s2 reads addr 7 in the same cycle → s2 returns 0xA5A5A5A5. The next s2 read of addr 7 returns 0x5A5A5A5A.
- **Freeze mid-pipeline:** accept an s1 read, then drop `clken` for 3 cycles → `waitrequest` high and `readdatavalid` does not advance during the stall. The response completes the remaining latency after `clken` returns, and no requests are lost.
- **Reset mid-clear and out-of-range:** assert `reset` at clear count 9 → after release, the clear restarts from 0 and takes a full 16 cycles. In READY, a write to addr 20 (DEPTH=16) changes no word in 0..15, and a read of addr 20 returns 0 with `readdatavalid`.
